mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL set the maximum number of memory-wait cycles (range 1..255) and SHALL only be used when the timeout feature is compiled in.
REQ-002 Ports SHALL be as follows; clk in 1, single rising-edge clock.
REQ-003 rst in 1: asynchronous, active-high reset.
REQ-004 cpuReq in 1: CPU access request, held until cpuRdy.
REQ-005 cpuWe in 1: CPU write enable (1=write, 0=read).
REQ-006 cpuAddr in 12: CPU address.
REQ-007 cpuWdata in 16: CPU write data.
REQ-008 cpuRdy out 1: one-cycle completion pulse to CPU.
REQ-009 cpuRdata out 32: CPU read data, zero whenever cpuRdy=0.
REQ-010 devReq, devWe, devAddr[12], devWdata[16], devRdy, devRdata[32] SHALL mirror the CPU ports for the second requester.
REQ-011 memReq out 1: memory strobe. memWe out 1. memAddr out 12. memWdata out 16.
REQ-012 addrCmp out 3: component select; 3'd2 when memAddr[11:8]==0, else 3'd3, and 3'd0 when memReq=0.
REQ-013 memRdy in 1: memory completion. memRdata in 32: memory read data, valid only with memRdy.
REQ-014 err out 1: one-cycle timeout pulse, coincident with the aborted requester's rdy.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-016 IDLE: if either req=1, the arbiter SHALL grant one requester, latch its we/addr/wdata into memWe/memAddr/memWdata, and enter ACCESS on the next edge.
REQ-017 Arbitration SHALL be round-robin. With both requesting, the requester not granted last wins. After reset, the CPU wins.
REQ-018 A single requester SHALL be granted regardless of the round-robin pointer.
REQ-019 The pointer SHALL update only on entry to RESP.
REQ-020 ACCESS: memReq=1 and addrCmp decoded from the latched address. memWe/memAddr/memWdata SHALL stay stable until memRdy.
REQ-021 ACCESS with memRdy=1: memRdata SHALL be latched, memReq SHALL drop on the next edge, and the FSM SHALL enter RESP.
REQ-022 ACCESS with memRdy=1 in the first ACCESS cycle SHALL be accepted, giving a minimum latency of req@cycle0 -> memReq@cycle1 -> rdy@cycle2.
REQ-023 RESP: exactly one cycle of the granted requester's rdy=1 and its rdata=latched memRdata.
REQ-024 In RESP, rdata SHALL be zero on writes.
REQ-025 RESP SHALL always return to IDLE, so back-to-back grants are separated by one idle cycle.
REQ-026 The non-granted requester's rdy/rdata SHALL stay 0.
REQ-027 A requester dropping req mid-transaction SHALL NOT abort it; the transaction SHALL complete and rdy SHALL still pulse.
REQ-028 memRdy asserted outside ACCESS SHALL be ignored.
REQ-029 A new req arriving during ACCESS or RESP SHALL be held off until IDLE.

Reset
REQ-030 On rst=1, the FSM SHALL go to IDLE and the pointer SHALL favour the CPU.
REQ-031 On rst=1, all outputs SHALL be 0 (memReq, memWe, memAddr, memWdata, addrCmp, cpuRdy, cpuRdata, devRdy, devRdata, err).
REQ-032 Reset asserted mid-ACCESS SHALL abandon the transaction without any rdy pulse.

Configuration
REQ-033 Macro ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on ACCESS entry and increment each ACCESS cycle without memRdy.
REQ-034 Macro ARB_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES, memReq SHALL drop and the FSM SHALL enter RESP with rdata=0 and err=1 for that cycle.
REQ-035 Macro ARB_TIMEOUT_EN defined: memRdy arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win, giving a normal completion with err=0.
REQ-036 Macro ARB_TIMEOUT_EN undefined: no counter SHALL be built, ACCESS SHALL wait indefinitely for memRdy, and err SHALL be tied 0.

Verification
REQ-037 CPU read, cpuAddr=0x0A5, memRdy one cycle after memReq with memRdata=0x12345678 -> addrCmp=2 during ACCESS; cpuRdy pulses once with cpuRdata=0x12345678; devRdy=0.
REQ-038 dev write, devAddr=0x3F0, devWdata=0xBEEF -> memWe=1, memWdata=0xBEEF, addrCmp=3; devRdy pulses with devRdata=0.
REQ-039 Both requesters held high for 4 transactions after reset, memRdy immediate -> grant order CPU, dev, CPU, dev, each rdy 3 cycles apart.
REQ-040 Reset asserted while memReq=1 -> all outputs 0 at once; no rdy pulse; first grant after release goes to the CPU.
REQ-041 Timeout build with TIMEOUT_CYCLES=4 and memRdy never asserted -> memReq high exactly 4 cycles, then cpuRdy=1, err=1, cpuRdata=0.
REQ-042 Non-timeout build with memRdy delayed 300 cycles -> memReq stays high for 300 cycles, then a normal completion with err=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU / device) round-robin arbiter in front of a single memory port.
// Optional memory-wait timeout is compiled in with `define ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpuReq,
    input  logic        cpuWe,
    input  logic [11:0] cpuAddr,
    input  logic [15:0] cpuWdata,
    output logic        cpuRdy,
    output logic [31:0] cpuRdata,
    input  logic        devReq,
    input  logic        devWe,
    input  logic [11:0] devAddr,
    input  logic [15:0] devWdata,
    output logic        devRdy,
    output logic [31:0] devRdata,
    output logic        memReq,
    output logic        memWe,
    output logic [11:0] memAddr,
    output logic [15:0] memWdata,
    output logic [2:0]  addrCmp,
    input  logic        memRdy,
    input  logic [31:0] memRdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        any_req;
    logic        pick_dev;
    logic        grant_dev;
    logic        last_dev;
    logic        timeout_hit;
    logic        err_flag;
    logic [31:0] rdata_q;
    logic [31:0] resp_data;
    logic        in_resp;

    assign any_req = cpuReq | devReq;

    // With both requesting, the one not served last wins; a lone requester always wins.
    always_comb begin
        pick_dev = 1'b0;
        if (cpuReq && devReq) begin
            pick_dev = ~last_dev;
        end else begin
            pick_dev = devReq;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign timeout_hit = (state == ACCESS) && !memRdy
                         && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
            err_flag <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wait_cnt <= 8'd0;
            end else if (state == ACCESS && !memRdy) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            // memRdy takes priority over an expiring counter.
            if (state == ACCESS) begin
                if (memRdy) begin
                    err_flag <= 1'b0;
                end else if (timeout_hit) begin
                    err_flag <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_timeout_param;

    assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
    assign timeout_hit          = 1'b0;
    assign err_flag             = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (memRdy || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant, latched request fields, response data and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_dev <= 1'b0;
            last_dev  <= 1'b1;
            memWe     <= 1'b0;
            memAddr   <= 12'd0;
            memWdata  <= 16'd0;
            rdata_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_dev <= pick_dev;
                        memWe     <= pick_dev ? devWe    : cpuWe;
                        memAddr   <= pick_dev ? devAddr  : cpuAddr;
                        memWdata  <= pick_dev ? devWdata : cpuWdata;
                    end
                end
                ACCESS: begin
                    if (memRdy) begin
                        rdata_q  <= memRdata;
                        last_dev <= grant_dev;
                    end else if (timeout_hit) begin
                        rdata_q  <= 32'd0;
                        last_dev <= grant_dev;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        in_resp   = (state == RESP);
        memReq    = (state == ACCESS);
        addrCmp   = 3'd0;
        if (memReq) begin
            addrCmp = (memAddr[11:8] == 4'd0) ? 3'd2 : 3'd3;
        end
        resp_data = memWe ? 32'd0 : rdata_q;
        cpuRdy    = in_resp && !grant_dev;
        devRdy    = in_resp && grant_dev;
        cpuRdata  = cpuRdy ? resp_data : 32'd0;
        devRdata  = devRdy ? resp_data : 32'd0;
        err       = in_resp && err_flag;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, reads/writes, round-robin order, hold-off,
// reset mid-access and long memory waits (timeout behaviour when ARB_TIMEOUT_EN is defined).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpuReq, cpuWe, devReq, devWe, memRdy;
    logic [11:0] cpuAddr, devAddr;
    logic [15:0] cpuWdata, devWdata;
    logic [31:0] memRdata;
    logic        cpuRdy, devRdy, memReq, memWe, err;
    logic [31:0] cpuRdata, devRdata;
    logic [11:0] memAddr;
    logic [15:0] memWdata;
    logic [2:0]  addrCmp;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int hi_cnt;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
        .cpuRdy(cpuRdy), .cpuRdata(cpuRdata),
        .devReq(devReq), .devWe(devWe), .devAddr(devAddr), .devWdata(devWdata),
        .devRdy(devRdy), .devRdata(devRdata),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .addrCmp(addrCmp), .memRdy(memRdy), .memRdata(memRdata), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        cpuReq = 0; cpuWe = 0; cpuAddr = 0; cpuWdata = 0;
        devReq = 0; devWe = 0; devAddr = 0; devWdata = 0;
        memRdy = 0; memRdata = 0;
        tick(); tick();
        check("rst_memReq", memReq, 0);
        check("rst_addrCmp", addrCmp, 0);
        check("rst_memAddr", memAddr, 0);
        check("rst_rdy", {cpuRdy, devRdy, err}, 0);
        rst = 1'b0;

        // CPU read, memory answers in the first access cycle
        cpuReq = 1; cpuWe = 0; cpuAddr = 12'h0A5;
        tick();
        check("t1_memReq", memReq, 1);
        check("t1_addrCmp", addrCmp, 2);
        check("t1_memAddr", memAddr, 12'h0A5);
        check("t1_cpuRdy_early", cpuRdy, 0);
        memRdy = 1; memRdata = 32'h12345678;
        tick();
        check("t1_cpuRdy", cpuRdy, 1);
        check("t1_cpuRdata", cpuRdata, 32'h12345678);
        check("t1_devRdy", {devRdy, devRdata}, 0);
        check("t1_memReq_drop", memReq, 0);
        check("t1_err", err, 0);
        memRdy = 0; memRdata = 0; cpuReq = 0;
        tick();
        check("t1_idle", {cpuRdy, cpuRdata}, 0);

        // Dev write; dev drops req mid-access, CPU arrives and is held off
        devReq = 1; devWe = 1; devAddr = 12'h3F0; devWdata = 16'hBEEF;
        tick();
        check("t2_memWe", memWe, 1);
        check("t2_memWdata", memWdata, 16'hBEEF);
        check("t2_addrCmp", addrCmp, 3);
        devReq = 0;
        cpuReq = 1; cpuWe = 0; cpuAddr = 12'h055;
        tick();
        check("t2_hold_memAddr", memAddr, 12'h3F0);
        check("t2_hold_memReq", memReq, 1);
        memRdy = 1; memRdata = 32'hDEADBEEF;
        tick();
        check("t2_devRdy", devRdy, 1);
        check("t2_devRdata", devRdata, 0);
        check("t2_cpuRdy", cpuRdy, 0);
        memRdy = 0;
        tick();
        check("t2_gap_memReq", memReq, 0);
        tick();
        check("t2_cpu_memAddr", memAddr, 12'h055);
        check("t2_cpu_addrCmp", addrCmp, 2);
        memRdy = 1; memRdata = 32'h0BADF00D;
        tick();
        check("t2_cpuRdata", cpuRdata, 32'h0BADF00D);
        cpuReq = 0; memRdy = 0;
        tick();

        // memRdy while idle is ignored
        memRdy = 1; memRdata = 32'hFFFFFFFF;
        tick();
        check("idle_memRdy", {memReq, cpuRdy, devRdy}, 0);
        memRdy = 0;
        tick();

        // Reset in the middle of an access (pointer currently favours the device)
        devReq = 1; devWe = 0; devAddr = 12'h3F0;
        tick();
        check("t4_memReq", memReq, 1);
        rst = 1;
        #1;
        check("t4_rst_memReq", memReq, 0);
        check("t4_rst_addrCmp", addrCmp, 0);
        check("t4_rst_memAddr", memAddr, 0);
        check("t4_rst_rdy", {devRdy, cpuRdy, err}, 0);
        devReq = 0; memRdy = 1;
        tick();
        rst = 0; memRdy = 0;
        tick();
        check("t4_no_pulse", {devRdy, cpuRdy, memReq}, 0);
        cpuReq = 1; cpuWe = 0; cpuAddr = 12'h0A5;
        devReq = 1; devWe = 1;
        tick();
        check("t4_first_cpu", memAddr, 12'h0A5);
        memRdy = 1; memRdata = 32'h11112222;
        tick();
        check("t4_cpuRdy", {cpuRdy, devRdy}, 2'b10);
        cpuReq = 0; devReq = 0; memRdy = 0;
        tick();

        // Round robin after reset, both held, memory immediate
        rst = 1;
        tick();
        rst = 0;
        cpuReq = 1; cpuWe = 0; cpuAddr = 12'h100;
        devReq = 1; devWe = 0; devAddr = 12'h010;
        memRdy = 1;
        for (int i = 0; i < 4; i++) begin
            memRdata = 32'hCAFE0000 + 32'(i);
            tick();
            check("rr_memAddr", memAddr, (i % 2 == 0) ? 12'h100 : 12'h010);
            tick();
            check("rr_rdy", {cpuRdy, devRdy}, (i % 2 == 0) ? 2'b10 : 2'b01);
            check("rr_rdata", (i % 2 == 0) ? cpuRdata : devRdata, 32'hCAFE0000 + 32'(i));
            if (i == 3) begin
                cpuReq = 0; devReq = 0;
            end
            tick();
            check("rr_gap", {memReq, cpuRdy, devRdy}, 0);
        end
        memRdy = 0;
        tick();

`ifdef ARB_TIMEOUT_EN
        // Timeout with memory never answering
        cpuReq = 1; cpuWe = 0; cpuAddr = 12'h200;
        tick();
        hi_cnt = 0;
        for (int k = 0; k < 10 && memReq; k++) begin
            hi_cnt++;
            tick();
        end
        check("to_hi_cycles", hi_cnt, 4);
        check("to_cpuRdy", cpuRdy, 1);
        check("to_err", err, 1);
        check("to_cpuRdata", cpuRdata, 0);
        cpuReq = 0;
        tick();
        check("to_err_pulse", err, 0);
        // memRdy in the last allowed cycle wins over the timeout
        cpuReq = 1;
        tick();
        tick(); tick(); tick();
        memRdy = 1; memRdata = 32'h55AA55AA;
        tick();
        check("to_race_rdy", cpuRdy, 1);
        check("to_race_err", err, 0);
        check("to_race_rdata", cpuRdata, 32'h55AA55AA);
        cpuReq = 0; memRdy = 0;
        tick();
`else
        // Long memory wait, no timeout
        cpuReq = 1; cpuWe = 1; cpuAddr = 12'h200; cpuWdata = 16'h1234;
        tick();
        hi_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            if (memReq) hi_cnt++;
            if (k == 299) memRdy = 1;
            tick();
        end
        check("long_hi_cycles", hi_cnt, 300);
        check("long_cpuRdy", cpuRdy, 1);
        check("long_err", err, 0);
        check("long_cpuRdata", cpuRdata, 0);
        check("long_memReq_drop", memReq, 0);
        cpuReq = 0; memRdy = 0;
        tick();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
